// File: rtl/vga_char_bounce.sv
// Moving CHAR_W x CHAR_H bitmap overlay that bounces off the active-area walls; pix_data lags pix_x/pix_y by 2 cycles.
// Optional VGA_BOUNCE_COLOR_EN: glyph colour steps through an 8-entry palette on every bounce.
module vga_char_bounce #(
  parameter int          H_VALID  = 640,
  parameter int          V_VALID  = 480,
  parameter int          CHAR_W   = 256,
  parameter int          CHAR_H   = 64,
  parameter int          INIT_X   = 192,
  parameter int          INIT_Y   = 208,
  parameter int          X_STEP   = 2,
  parameter int          Y_STEP   = 1,
  parameter logic [15:0] FG_COLOR = 16'hFEC0,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic                      vga_clk,
  input  logic                      sys_rst_n,
  input  logic [9:0]                pix_x,
  input  logic [9:0]                pix_y,
  input  logic                      move_en,
  output logic [$clog2(CHAR_H)-1:0] rom_addr,
  input  logic [CHAR_W-1:0]         rom_data,
  output logic [15:0]               pix_data,
  output logic                      edge_hit
);

  localparam int          AW    = $clog2(CHAR_H);
  localparam int          CW    = $clog2(CHAR_W);
  localparam logic [10:0] X_MAX = 11'(H_VALID - CHAR_W);
  localparam logic [10:0] Y_MAX = 11'(V_VALID - CHAR_H);
  localparam logic [10:0] XS    = 11'(X_STEP);
  localparam logic [10:0] YS    = 11'(Y_STEP);
  localparam logic [10:0] CW11  = 11'(CHAR_W);
  localparam logic [10:0] CH11  = 11'(CHAR_H);

  logic [9:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic          dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic          hit_q;
  logic [CW-1:0] col_q, col_d;
  logic [15:0]   pix_data_q, pix_data_d;
  logic          edge_hit_q, edge_hit_d;
  logic [15:0]   fg_color;

  logic [10:0]   px, py, bx, by;
  logic          in_x, in_y, in_box;
  logic          frame_end, upd, bounce_x, bounce_y;
  logic [CW-1:0] bit_sel;

  always_comb begin
    px       = {1'b0, pix_x};
    py       = {1'b0, pix_y};
    bx       = {1'b0, pos_x_q};
    by       = {1'b0, pos_y_q};
    in_x     = (pix_x != 10'h3FF) && (px >= bx) && (px < bx + CW11);
    in_y     = (pix_y != 10'h3FF) && (py >= by) && (py < by + CH11);
    in_box   = in_x && in_y;
    rom_addr = in_box ? AW'(pix_y - pos_y_q) : '0;
    col_d    = CW'(pix_x - pos_x_q);
    // ROM rows are stored MSB-first, so column 0 maps to the top bit
    bit_sel    = CW'(CHAR_W - 1) - col_q;
    pix_data_d = (hit_q && rom_data[bit_sel]) ? fg_color : BG_COLOR;
  end

  always_comb begin
    frame_end = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));
    upd       = frame_end && move_en;
    pos_x_d   = pos_x_q;
    dir_x_d   = dir_x_q;
    bounce_x  = 1'b0;
    pos_y_d   = pos_y_q;
    dir_y_d   = dir_y_q;
    bounce_y  = 1'b0;
    if (dir_x_q) begin
      if (bx + XS > X_MAX) begin
        pos_x_d  = X_MAX[9:0];
        dir_x_d  = 1'b0;
        bounce_x = 1'b1;
      end else begin
        pos_x_d = 10'(bx + XS);
      end
    end else if (bx < XS) begin
      pos_x_d  = 10'd0;
      dir_x_d  = 1'b1;
      bounce_x = 1'b1;
    end else begin
      pos_x_d = 10'(bx - XS);
    end
    if (dir_y_q) begin
      if (by + YS > Y_MAX) begin
        pos_y_d  = Y_MAX[9:0];
        dir_y_d  = 1'b0;
        bounce_y = 1'b1;
      end else begin
        pos_y_d = 10'(by + YS);
      end
    end else if (by < YS) begin
      pos_y_d  = 10'd0;
      dir_y_d  = 1'b1;
      bounce_y = 1'b1;
    end else begin
      pos_y_d = 10'(by - YS);
    end
    // A corner counts as a single bounce event
    edge_hit_d = upd && (bounce_x || bounce_y);
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pos_x_q    <= 10'(INIT_X);
      pos_y_q    <= 10'(INIT_Y);
      dir_x_q    <= 1'b1;
      dir_y_q    <= 1'b1;
      hit_q      <= 1'b0;
      col_q      <= '0;
      pix_data_q <= BG_COLOR;
      edge_hit_q <= 1'b0;
    end else begin
      hit_q      <= in_box;
      col_q      <= col_d;
      pix_data_q <= pix_data_d;
      edge_hit_q <= edge_hit_d;
      if (upd) begin
        pos_x_q <= pos_x_d;
        pos_y_q <= pos_y_d;
        dir_x_q <= dir_x_d;
        dir_y_q <= dir_y_d;
      end
    end
  end

`ifdef VGA_BOUNCE_COLOR_EN
  logic [2:0] cidx_q;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)      cidx_q <= 3'd0;
    else if (edge_hit_d) cidx_q <= cidx_q + 3'd1;
  end

  always_comb begin
    fg_color = 16'hFEC0;
    case (cidx_q)
      3'd0:    fg_color = 16'hFEC0;
      3'd1:    fg_color = 16'hF800;
      3'd2:    fg_color = 16'h07E0;
      3'd3:    fg_color = 16'h001F;
      3'd4:    fg_color = 16'hFFE0;
      3'd5:    fg_color = 16'h07FF;
      3'd6:    fg_color = 16'hF81F;
      default: fg_color = 16'hFFFF;
    endcase
  end
`else
  assign fg_color = FG_COLOR;
`endif

  assign pix_data = pix_data_q;
  assign edge_hit = edge_hit_q;

endmodule

// File: tb/tb_vga_char_bounce.sv
// Self-checking bench for vga_char_bounce: default instance plus a corner-start instance.
module tb_vga_char_bounce;

  localparam logic [15:0] FG = 16'hFEC0;
  localparam logic [15:0] BG = 16'h0000;
`ifdef VGA_BOUNCE_COLOR_EN
  localparam logic [15:0] C1 = 16'hF800;
`else
  localparam logic [15:0] C1 = 16'hFEC0;
`endif

  logic         vga_clk   = 1'b0;
  logic         sys_rst_n = 1'b1;
  logic [9:0]   pix_x     = 10'h3FF;
  logic [9:0]   pix_y     = 10'h3FF;
  logic         move_en   = 1'b0;
  logic [255:0] rom_data  = '0;
  logic [5:0]   rom_addr;
  logic [15:0]  pix_data;
  logic         edge_hit;

  logic [9:0]   pix_x_c   = 10'h3FF;
  logic [9:0]   pix_y_c   = 10'h3FF;
  logic         move_en_c = 1'b0;
  logic [5:0]   rom_addr_c;
  logic [15:0]  pix_data_c;
  logic         edge_hit_c;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  always #5 vga_clk = ~vga_clk;

  vga_char_bounce dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .move_en(move_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_data(pix_data), .edge_hit(edge_hit)
  );

  vga_char_bounce #(.INIT_X(382), .INIT_Y(414), .X_STEP(2), .Y_STEP(2)) dut_c (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x_c), .pix_y(pix_y_c),
    .move_en(move_en_c), .rom_addr(rom_addr_c), .rom_data(rom_data),
    .pix_data(pix_data_c), .edge_hit(edge_hit_c)
  );

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic test_reset();
    #1 sys_rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (pix_data !== BG) begin failures++; $display("FAIL reset_pix got %h want %h", pix_data, BG); end
    checks++; if (edge_hit !== 1'b0) begin failures++; $display("FAIL reset_edge got %b want 0", edge_hit); end
    checks++; if (dut.pos_x_q !== 10'd192 || dut.pos_y_q !== 10'd208) begin
      failures++; $display("FAIL reset_pos got %0d,%0d want 192,208", dut.pos_x_q, dut.pos_y_q); end
    checks++; if (dut.dir_x_q !== 1'b1 || dut.dir_y_q !== 1'b1) begin
      failures++; $display("FAIL reset_dir got %b%b want 11", dut.dir_x_q, dut.dir_y_q); end
    checks++; if (dut_c.pos_x_q !== 10'd382 || dut_c.pos_y_q !== 10'd414) begin
      failures++; $display("FAIL reset_pos_c got %0d,%0d want 382,414", dut_c.pos_x_q, dut_c.pos_y_q); end
    sys_rst_n = 1'b1;
    tick();
    checks++; if (pix_data !== BG) begin failures++; $display("FAIL release_pix got %h want %h", pix_data, BG); end
  endtask

  task automatic test_draw();
    localparam int N = 8;
    logic [9:0]   tx[N];
    logic [9:0]   ty[N];
    logic [255:0] trom[N];
    logic [5:0]   taddr[N];
    logic [15:0]  texp[N];
    logic [255:0] msb, lsb, ones, b254;
    logic [15:0]  e;
    msb = '0; msb[255] = 1'b1;
    lsb = '0; lsb[0] = 1'b1;
    b254 = '0; b254[254] = 1'b1;
    ones = '1;
    tx[0] = 10'd192;  ty[0] = 10'd208;  trom[0] = msb;  taddr[0] = 6'd0;  texp[0] = FG;
    tx[1] = 10'd191;  ty[1] = 10'd208;  trom[1] = ones; taddr[1] = 6'd0;  texp[1] = BG;
    tx[2] = 10'h3FF;  ty[2] = 10'h3FF;  trom[2] = ones; taddr[2] = 6'd0;  texp[2] = BG;
    tx[3] = 10'd447;  ty[3] = 10'd271;  trom[3] = lsb;  taddr[3] = 6'd63; texp[3] = FG;
    tx[4] = 10'd448;  ty[4] = 10'd271;  trom[4] = ones; taddr[4] = 6'd0;  texp[4] = BG;
    tx[5] = 10'd447;  ty[5] = 10'd271;  trom[5] = msb;  taddr[5] = 6'd63; texp[5] = BG;
    tx[6] = 10'd193;  ty[6] = 10'd209;  trom[6] = b254; taddr[6] = 6'd1;  texp[6] = FG;
    tx[7] = 10'd200;  ty[7] = 10'd272;  trom[7] = ones; taddr[7] = 6'd0;  texp[7] = BG;
    move_en = 1'b0;
    // ROM word for entry i is presented one cycle after its coordinate
    for (int i = 0; i <= N; i++) begin
      if (i < N) begin
        pix_x = tx[i]; pix_y = ty[i];
        exp_q.push_back(texp[i]);
      end
      if (i > 0) rom_data = trom[i-1];
      #1;
      if (i < N) begin
        checks++;
        if (rom_addr !== taddr[i]) begin
          failures++; $display("FAIL draw_addr[%0d] got %0d want %0d", i, rom_addr, taddr[i]);
        end
      end
      tick();
      if (exp_q.size() >= 2 || (i == N && exp_q.size() > 0)) begin
        e = exp_q.pop_front();
        checks++;
        if (pix_data !== e) begin
          failures++; $display("FAIL draw_pix[%0d] got %h want %h", i - 1, pix_data, e);
        end
      end
    end
    pix_x = 10'h3FF; pix_y = 10'h3FF;
  endtask

  task automatic test_right_bounce();
    int total;
    logic eh0, eh1;
    move_en = 1'b1;
    total = 0;
    for (int f = 1; f <= 98; f++) begin
      pix_x = 10'd639; pix_y = 10'd479;
      tick(); eh0 = edge_hit;
      pix_x = 10'h3FF; pix_y = 10'h3FF;
      tick(); eh1 = edge_hit;
      total += int'(eh0) + int'(eh1);
      if (f == 96) begin
        checks++; if (dut.pos_x_q !== 10'd384 || dut.pos_y_q !== 10'd304 || {eh0, eh1} !== 2'b00) begin
          failures++; $display("FAIL rb_f96 got %0d,%0d hit %b%b want 384,304 hit 00", dut.pos_x_q, dut.pos_y_q, eh0, eh1); end
      end
      if (f == 97) begin
        checks++; if (dut.pos_x_q !== 10'd384 || dut.pos_y_q !== 10'd305 || dut.dir_x_q !== 1'b0 || {eh0, eh1} !== 2'b10) begin
          failures++; $display("FAIL rb_f97 got %0d,%0d dir %b hit %b%b want 384,305 dir 0 hit 10", dut.pos_x_q, dut.pos_y_q, dut.dir_x_q, eh0, eh1); end
      end
      if (f == 98) begin
        checks++; if (dut.pos_x_q !== 10'd382 || dut.pos_y_q !== 10'd306 || {eh0, eh1} !== 2'b00) begin
          failures++; $display("FAIL rb_f98 got %0d,%0d hit %b%b want 382,306 hit 00", dut.pos_x_q, dut.pos_y_q, eh0, eh1); end
      end
    end
    checks++; if (total !== 1) begin failures++; $display("FAIL rb_pulses got %0d want 1", total); end
  endtask

  task automatic test_freeze();
    int total;
    move_en = 1'b0;
    total = 0;
    for (int f = 0; f < 10; f++) begin
      pix_x = 10'd639; pix_y = 10'd479;
      tick(); total += int'(edge_hit);
      pix_x = 10'h3FF; pix_y = 10'h3FF;
      tick(); total += int'(edge_hit);
    end
    checks++; if (dut.pos_x_q !== 10'd382 || dut.pos_y_q !== 10'd306 || total !== 0) begin
      failures++; $display("FAIL freeze got %0d,%0d pulses %0d want 382,306 pulses 0", dut.pos_x_q, dut.pos_y_q, total); end
    move_en = 1'b1;
    pix_x = 10'd639; pix_y = 10'd479;
    tick();
    pix_x = 10'h3FF; pix_y = 10'h3FF;
    tick();
    checks++; if (dut.pos_x_q !== 10'd380 || dut.pos_y_q !== 10'd307) begin
      failures++; $display("FAIL resume got %0d,%0d want 380,307", dut.pos_x_q, dut.pos_y_q); end
    move_en = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [15:0] e;
    rom_data = '1;
    pix_x = 10'd380; pix_y = 10'd307;
    exp_q.push_back(C1);
    tick(); tick();
    e = exp_q.pop_front();
    checks++; if (pix_data !== e) begin failures++; $display("FAIL mid_pre got %h want %h", pix_data, e); end
    #2 sys_rst_n = 1'b0;
    #1;
    checks++; if (pix_data !== BG) begin failures++; $display("FAIL mid_async got %h want %h", pix_data, BG); end
    checks++; if (dut.pos_x_q !== 10'd192 || dut.pos_y_q !== 10'd208 || dut.dir_x_q !== 1'b1 || dut.dir_y_q !== 1'b1) begin
      failures++; $display("FAIL mid_state got %0d,%0d dir %b%b want 192,208 dir 11", dut.pos_x_q, dut.pos_y_q, dut.dir_x_q, dut.dir_y_q); end
    exp_q.delete();
    tick();
    sys_rst_n = 1'b1;
    pix_x = 10'h3FF; pix_y = 10'h3FF;
    tick(); tick();
    checks++; if (pix_data !== BG) begin failures++; $display("FAIL mid_idle got %h want %h", pix_data, BG); end
    pix_x = 10'd192; pix_y = 10'd208;
    exp_q.push_back(FG);
    tick();
    checks++; if (pix_data !== BG) begin failures++; $display("FAIL mid_lat1 got %h want %h", pix_data, BG); end
    tick();
    e = exp_q.pop_front();
    checks++; if (pix_data !== e) begin failures++; $display("FAIL mid_color0 got %h want %h", pix_data, e); end
    pix_x = 10'h3FF; pix_y = 10'h3FF;
  endtask

  task automatic test_corner();
    int pulses;
    logic [15:0] e;
    logic [255:0] msb;
    msb = '0; msb[255] = 1'b1;
    move_en_c = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      pulses = 0;
      pix_x_c = 10'd639; pix_y_c = 10'd479;
      tick(); pulses += int'(edge_hit_c);
      pix_x_c = 10'h3FF; pix_y_c = 10'h3FF;
      tick(); pulses += int'(edge_hit_c);
      tick(); pulses += int'(edge_hit_c);
      if (f == 1) begin
        checks++; if (dut_c.pos_x_q !== 10'd384 || dut_c.pos_y_q !== 10'd416 || pulses !== 0) begin
          failures++; $display("FAIL corner_f1 got %0d,%0d pulses %0d want 384,416 pulses 0", dut_c.pos_x_q, dut_c.pos_y_q, pulses); end
      end
      if (f == 2) begin
        checks++; if (dut_c.pos_x_q !== 10'd384 || dut_c.pos_y_q !== 10'd416 || {dut_c.dir_x_q, dut_c.dir_y_q} !== 2'b00 || pulses !== 1) begin
          failures++; $display("FAIL corner_f2 got %0d,%0d dir %b%b pulses %0d want 384,416 dir 00 pulses 1",
                               dut_c.pos_x_q, dut_c.pos_y_q, dut_c.dir_x_q, dut_c.dir_y_q, pulses); end
      end
      if (f == 3) begin
        checks++; if (dut_c.pos_x_q !== 10'd382 || dut_c.pos_y_q !== 10'd414 || pulses !== 0) begin
          failures++; $display("FAIL corner_f3 got %0d,%0d pulses %0d want 382,414 pulses 0", dut_c.pos_x_q, dut_c.pos_y_q, pulses); end
      end
      if (f >= 2) begin
        pix_x_c = dut_c.pos_x_q; pix_y_c = dut_c.pos_y_q;
        rom_data = msb;
        exp_q.push_back(C1);
        tick(); tick();
        e = exp_q.pop_front();
        checks++; if (pix_data_c !== e) begin failures++; $display("FAIL corner_color[%0d] got %h want %h", f, pix_data_c, e); end
        pix_x_c = 10'h3FF; pix_y_c = 10'h3FF;
        tick();
      end
    end
    move_en_c = 1'b0;
  endtask

  initial begin
    test_reset();
    test_draw();
    test_right_bounce();
    test_freeze();
    test_reset_midframe();
    test_corner();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
